// File: rtl/fetch_unit_pkg.sv
// Shared CPU constants and F/D register payload type used by the fetch stage.
package fetch_unit_pkg;

  localparam logic [31:0] CPU_RESET_PC = 32'h0000_3000;
  localparam logic [31:0] CPU_EXC_PC   = 32'h0000_4180;
  localparam logic [31:0] CPU_IM_LO    = 32'h0000_3000;
  localparam logic [31:0] CPU_IM_HI    = 32'h0000_6FFC;
  localparam logic [4:0]  EXC_ADEL     = 5'd4;
  localparam logic [4:0]  EXC_NONE     = 5'd0;
  localparam logic [31:0] NOP          = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [4:0]  exc;
    logic        bd;
  } fd_t;

  // Misaligned or outside the inclusive instruction window.
  function automatic logic adel_fault(input logic [31:0] pc,
                                      input logic [31:0] lo,
                                      input logic [31:0] hi);
    return (pc[1:0] != 2'b00) || (pc < lo) || (pc > hi);
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction memory port: fetch drives the address, memory returns data combinationally.
interface fetch_unit_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;

  modport master (output imem_addr, input imem_rdata);
  modport slave  (input imem_addr, output imem_rdata);
endinterface

// File: rtl/fetch_unit_fd_reg.sv
// F/D pipeline register: exception flush beats stall, stall beats eret flush and load.
module fd_reg
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RST_PC   = CPU_RESET_PC,
  parameter logic [31:0] ENTRY_PC = CPU_EXC_PC
) (
  input  logic clk,
  input  logic reset,
  input  logic stall,
  input  logic exc_flush,
  input  logic flush,
  input  fd_t  din,
  output fd_t  dout
);

  fd_t fd_q, fd_d;

  // Select the next F/D contents.
  always_comb begin
    fd_d = fd_q;
    if (exc_flush) begin
      fd_d = '{instr: NOP, pc: ENTRY_PC, exc: EXC_NONE, bd: 1'b0};
    end else if (stall) begin
      fd_d = fd_q;
    end else if (flush) begin
      fd_d = '{instr: NOP, pc: din.pc, exc: EXC_NONE, bd: 1'b0};
    end else begin
      fd_d = din;
    end
  end

  // F/D state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      fd_q <= '{instr: NOP, pc: RST_PC, exc: EXC_NONE, bd: 1'b0};
    end else begin
      fd_q <= fd_d;
    end
  end

  assign dout = fd_q;

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: next-PC selection plus F/D register. Define FETCH_ADDR_CHECK_EN
// to raise AdEL on misaligned or out-of-window fetch addresses.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = CPU_RESET_PC,
  parameter logic [31:0] EXC_PC   = CPU_EXC_PC,
  parameter logic [31:0] IM_LO    = CPU_IM_LO,
  parameter logic [31:0] IM_HI    = CPU_IM_HI
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               redirect,
  input  logic [31:0]        redirect_pc,
  input  logic               D_is_branch,
  input  logic               req,
  input  logic               eret,
  input  logic [31:0]        epc,
  fetch_unit_if.master       imem,
  output logic [31:0]        D_instr,
  output logic [31:0]        D_pc,
  output logic [15:0]        D_imm16,
  output logic [4:0]         D_exc,
  output logic               D_bd
);

`ifdef FETCH_ADDR_CHECK_EN
  localparam logic ADDR_CHECK = 1'b1;
`else
  localparam logic ADDR_CHECK = 1'b0;
`endif

  logic [31:0] f_pc_q, f_pc_d;
  logic        addr_fault;
  fd_t         fd_in;
  fd_t         fd_out;

  // Next PC: req > stall hold > eret > redirect > sequential (wraps mod 2^32).
  always_comb begin
    f_pc_d = f_pc_q;
    if (req) begin
      f_pc_d = EXC_PC;
    end else if (stall) begin
      f_pc_d = f_pc_q;
    end else if (eret) begin
      f_pc_d = epc;
    end else if (redirect) begin
      f_pc_d = redirect_pc;
    end else begin
      f_pc_d = f_pc_q + 32'd4;
    end
  end

  // Fetch PC register.
  always_ff @(posedge clk) begin
    if (reset) begin
      f_pc_q <= RESET_PC;
    end else begin
      f_pc_q <= f_pc_d;
    end
  end

  assign imem.imem_addr = f_pc_q;
  assign addr_fault     = ADDR_CHECK & adel_fault(f_pc_q, IM_LO, IM_HI);

  // Build the F/D payload; a faulting fetch carries nop and AdEL.
  always_comb begin
    fd_in.pc = f_pc_q;
    fd_in.bd = D_is_branch;
    if (addr_fault) begin
      fd_in.instr = NOP;
      fd_in.exc   = EXC_ADEL;
    end else begin
      fd_in.instr = imem.imem_rdata;
      fd_in.exc   = EXC_NONE;
    end
  end

  fd_reg #(
    .RST_PC   (RESET_PC),
    .ENTRY_PC (EXC_PC)
  ) u_fd_reg (
    .clk       (clk),
    .reset     (reset),
    .stall     (stall),
    .exc_flush (req),
    .flush     (eret),
    .din       (fd_in),
    .dout      (fd_out)
  );

  assign D_instr = fd_out.instr;
  assign D_pc    = fd_out.pc;
  assign D_imm16 = fd_out.instr[15:0];
  assign D_exc   = fd_out.exc;
  assign D_bd    = fd_out.bd;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit; memory returns {16'hC0DE, addr[15:0]}.
module tb_fetch_unit;

`ifdef FETCH_ADDR_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, stall, redirect, D_is_branch, req, eret;
  logic [31:0] redirect_pc, epc;
  logic [31:0] D_instr, D_pc;
  logic [15:0] D_imm16;
  logic [4:0]  D_exc;
  logic        D_bd;
  int          n_checks = 0;
  int          n_fail   = 0;

  fetch_unit_if imem ();
  assign imem.imem_rdata = {16'hC0DE, imem.imem_addr[15:0]};

  fetch_unit dut (
    .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .D_is_branch(D_is_branch), .req(req),
    .eret(eret), .epc(epc), .imem(imem), .D_instr(D_instr), .D_pc(D_pc),
    .D_imm16(D_imm16), .D_exc(D_exc), .D_bd(D_bd)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_d(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                         input logic [4:0] exc, input logic bd);
    check_eq({tag, "_pc"}, D_pc, pc);
    check_eq({tag, "_instr"}, D_instr, instr);
    check_eq({tag, "_exc"}, {27'd0, D_exc}, {27'd0, exc});
    check_eq({tag, "_bd"}, {31'd0, D_bd}, {31'd0, bd});
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; D_is_branch = 1'b0;
    req = 1'b0; eret = 1'b0; redirect_pc = 32'd0; epc = 32'd0;
    step();
    step();
    check_eq("rst_fpc", imem.imem_addr, 32'h0000_3000);
    check_d("rst", 32'h0000_3000, 32'h0, 5'd0, 1'b0);

    // Three free-running cycles
    reset = 1'b0;
    step();
    check_d("seq0", 32'h0000_3000, 32'hC0DE_3000, 5'd0, 1'b0);
    check_eq("seq0_imm", {16'd0, D_imm16}, 32'h0000_3000);
    step();
    check_d("seq1", 32'h0000_3004, 32'hC0DE_3004, 5'd0, 1'b0);
    step();
    check_d("seq2", 32'h0000_3008, 32'hC0DE_3008, 5'd0, 1'b0);
    check_eq("seq2_fpc", imem.imem_addr, 32'h0000_300C);

    // Branch in D: delay slot with bd, then target
    D_is_branch = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_3100;
    step();
    check_d("ds", 32'h0000_300C, 32'hC0DE_300C, 5'd0, 1'b1);
    check_eq("br_fpc", imem.imem_addr, 32'h0000_3100);
    D_is_branch = 1'b0; redirect = 1'b0;
    step();
    check_d("tgt", 32'h0000_3100, 32'hC0DE_3100, 5'd0, 1'b0);

    // Stall two cycles with redirect pending
    stall = 1'b1; redirect = 1'b1; D_is_branch = 1'b1; redirect_pc = 32'h0000_3200;
    for (int i = 0; i < 2; i++) begin
      step();
      check_eq("stl_fpc", imem.imem_addr, 32'h0000_3104);
      check_d("stl", 32'h0000_3100, 32'hC0DE_3100, 5'd0, 1'b0);
    end
    stall = 1'b0;
    step();
    check_eq("unstl_fpc", imem.imem_addr, 32'h0000_3200);
    check_d("unstl", 32'h0000_3104, 32'hC0DE_3104, 5'd0, 1'b1);
    redirect = 1'b0; D_is_branch = 1'b0;
    step();
    check_d("unstl_tgt", 32'h0000_3200, 32'hC0DE_3200, 5'd0, 1'b0);

    // req overrides stall
    stall = 1'b1; req = 1'b1; eret = 1'b1; epc = 32'h0000_3010;
    step();
    check_eq("req_fpc", imem.imem_addr, 32'h0000_4180);
    check_d("req", 32'h0000_4180, 32'h0, 5'd0, 1'b0);
    stall = 1'b0; req = 1'b0; eret = 1'b0;
    step();
    check_d("hdl", 32'h0000_4180, 32'hC0DE_4180, 5'd0, 1'b0);
    eret = 1'b1; D_is_branch = 1'b1;
    step();
    check_eq("eret_fpc", imem.imem_addr, 32'h0000_3010);
    check_eq("eret_instr", D_instr, 32'h0);
    check_eq("eret_bd", {31'd0, D_bd}, 32'd0);
    eret = 1'b0; D_is_branch = 1'b0;
    step();
    check_d("ret", 32'h0000_3010, 32'hC0DE_3010, 5'd0, 1'b0);

    // Misaligned fetch
    redirect = 1'b1; redirect_pc = 32'h0000_3102;
    step();
    redirect = 1'b0;
    step();
    check_d("mis", 32'h0000_3102, CHK ? 32'h0 : 32'hC0DE_3102, CHK ? 5'd4 : 5'd0, 1'b0);
    check_eq("mis_fpc", imem.imem_addr, 32'h0000_3106);

    // Window top is legal, one word above is not
    redirect = 1'b1; redirect_pc = 32'h0000_6FFC;
    step();
    redirect = 1'b0;
    step();
    check_d("hi", 32'h0000_6FFC, 32'hC0DE_6FFC, 5'd0, 1'b0);
    step();
    check_d("above", 32'h0000_7000, CHK ? 32'h0 : 32'hC0DE_7000, CHK ? 5'd4 : 5'd0, 1'b0);

    // PC+4 wraps modulo 2^32
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect = 1'b0;
    step();
    check_d("top", 32'hFFFF_FFFC, CHK ? 32'h0 : 32'hC0DE_FFFC, CHK ? 5'd4 : 5'd0, 1'b0);
    check_eq("wrap_fpc", imem.imem_addr, 32'h0000_0000);

    // Reset during stall with pending redirect
    stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_3300; D_is_branch = 1'b1;
    step();
    reset = 1'b1; req = 1'b1;
    step();
    check_eq("rst2_fpc", imem.imem_addr, 32'h0000_3000);
    check_d("rst2", 32'h0000_3000, 32'h0, 5'd0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
